// File: rtl/regfile_burst_reader.sv
// Burst read sequencer: walks a wrap-around register-file address range and streams each word on valid/ready.
// Optional even-parity output `out_parity` is built when REGFILE_READER_PARITY_EN is defined.
module regfile_burst_reader #(
    parameter int Dwidth = 8,
    parameter int Awidth = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [Awidth-1:0] start_addr,
    input  logic [Awidth:0]   len,
    output logic [Awidth-1:0] raddr,
    input  logic [Dwidth-1:0] rdata,
    output logic [Dwidth-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
`ifdef REGFILE_READER_PARITY_EN
    ,
    output logic              out_parity
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    localparam logic [Awidth:0] RemainOne = 1;

    state_t            r_state;
    state_t            w_nextState;
    logic [Awidth-1:0] r_raddr;
    logic [Awidth:0]   r_remaining;
    logic [Dwidth-1:0] r_outData;
    logic              r_outValid;
    logic              r_outLast;
    logic              r_done;
    logic              w_launch;
    logic              w_zeroDone;
    logic              w_load;
    logic              w_finish;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_launch    = 1'b0;
        w_zeroDone  = 1'b0;
        w_load      = 1'b0;
        w_finish    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        w_launch    = 1'b1;
                        w_nextState = ST_RUN;
                    end else begin
                        w_zeroDone  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                // The output register refills whenever it is empty or its beat is leaving this edge.
                if (!r_outValid || out_ready) begin
                    w_load = 1'b1;
                    if (r_remaining == RemainOne) begin
                        w_nextState = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (r_outValid && out_ready) begin
                    w_finish    = 1'b1;
                    w_nextState = ST_IDLE;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_raddr     <= '0;
            r_remaining <= '0;
            r_outData   <= '0;
            r_outValid  <= 1'b0;
            r_outLast   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_zeroDone || w_finish;
            if (w_launch) begin
                r_raddr     <= start_addr;
                r_remaining <= len;
            end
            if (w_load) begin
                r_outData   <= rdata;
                r_outValid  <= 1'b1;
                r_outLast   <= (r_remaining == RemainOne);
                r_raddr     <= r_raddr + 1'b1;
                r_remaining <= r_remaining - 1'b1;
            end
            if (w_finish) begin
                r_outValid <= 1'b0;
                r_outLast  <= 1'b0;
            end
        end
    end

`ifdef REGFILE_READER_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity <= 1'b0;
        end else if (w_load) begin
            r_parity <= ^rdata;
        end
    end

    assign out_parity = r_parity;
`endif

    assign raddr     = r_raddr;
    assign out_data  = r_outData;
    assign out_valid = r_outValid;
    assign out_last  = r_outLast;
    assign done      = r_done;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_regfile_burst_reader.sv
// Randomized self-checking bench for regfile_burst_reader against a queue-based beat model.
// Parity checks are compiled in when REGFILE_READER_PARITY_EN is defined.
module tb_regfile_burst_reader;

    localparam int DW = 8;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW:0]   len = '0;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_last;
    logic          busy;
    logic          done;
`ifdef REGFILE_READER_PARITY_EN
    logic          out_parity;
`endif

    logic [7:0] mem [4];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    assign rdata = mem[raddr];

    regfile_burst_reader #(.Dwidth(DW), .Awidth(AW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .start_addr(start_addr),
        .len(len),
        .raddr(raddr),
        .rdata(rdata),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last(out_last),
        .busy(busy),
        .done(done)
`ifdef REGFILE_READER_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // readyMode: 0 = always ready, 1 = random ready, 2 = stall the first three valid cycles.
    task automatic applyStimulus(input logic [1:0] sa, input int l, input int readyMode, input bit injectStart);
        logic [7:0] exp[$];
        int         idx;
        int         stallCnt;
        bit         doneDue;
        bit         seenDone;
        bit         prevStall;
        logic [7:0] prevData;
        logic       r;

        exp = {};
        for (int i = 0; i < l; i++) begin
            exp.push_back(mem[(int'(sa) + i) % 4]);
        end

        @(negedge clk);
        start      = 1'b1;
        start_addr = sa;
        len        = 3'(l);
        out_ready  = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        start_addr = 2'($urandom_range(0, 3));
        len        = 3'($urandom_range(0, 7));

        if (l == 0) begin
            checkOutput("zlen_done", done, 1);
            checkOutput("zlen_busy", busy, 0);
            checkOutput("zlen_valid", out_valid, 0);
            @(negedge clk);
            checkOutput("zlen_done_clr", done, 0);
            checkOutput("zlen_valid2", out_valid, 0);
            checkOutput("zlen_busy2", busy, 0);
            return;
        end

        checkOutput("busy_on", busy, 1);
        checkOutput("raddr_load", raddr, sa);
        checkOutput("valid_pre", out_valid, 0);

        idx = 0;
        stallCnt = 0;
        doneDue = 0;
        seenDone = 0;
        prevStall = 0;
        prevData = '0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            start = (injectStart && k == 2);
            if (start) begin
                start_addr = 2'd1;
                len        = 3'd2;
            end
            checkOutput("done", done, doneDue);
            if (doneDue) begin
                checkOutput("busy_off", busy, 0);
                checkOutput("valid_off", out_valid, 0);
                seenDone = 1;
                break;
            end
            checkOutput("busy", busy, 1);
            if (prevStall) begin
                checkOutput("hold_data", out_data, prevData);
            end
            case (readyMode)
                1: r = ($urandom_range(0, 3) != 0);
                2: begin
                    if (out_valid && stallCnt < 3) begin
                        r = 1'b0;
                        stallCnt++;
                    end else begin
                        r = 1'b1;
                    end
                end
                default: r = 1'b1;
            endcase
            out_ready = r;
            prevStall = out_valid && !r;
            prevData  = out_data;
            if (out_valid && r) begin
                if (idx < l) begin
                    checkOutput("beat_data", out_data, exp[idx]);
                    checkOutput("beat_last", out_last, (idx == l - 1));
`ifdef REGFILE_READER_PARITY_EN
                    checkOutput("beat_parity", out_parity, ^exp[idx]);
`endif
                end else begin
                    checkOutput("extra_beat", 1, 0);
                end
                if (idx == l - 1) doneDue = 1;
                idx++;
            end
        end
        start = 1'b0;
        out_ready = 1'b1;
        if (!seenDone) checkOutput("timeout", 0, 1);
        checkOutput("beat_count", idx, l);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_valid"}, out_valid, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_raddr"}, raddr, 0);
        checkOutput({tag, "_data"}, out_data, 0);
        checkOutput({tag, "_last"}, out_last, 0);
`ifdef REGFILE_READER_PARITY_EN
        checkOutput({tag, "_parity"}, out_parity, 0);
`endif
    endtask

    initial begin
        logic [1:0] sa;
        int         l;

        mem[0] = 8'h11;
        mem[1] = 8'h22;
        mem[2] = 8'h33;
        mem[3] = 8'h44;
        repeat (2) @(negedge clk);
        checkResetValues("reset");
        rst_n = 1'b1;

        applyStimulus(2'd0, 4, 0, 1'b0);
        applyStimulus(2'd3, 3, 0, 1'b0);
        applyStimulus(2'd0, 4, 2, 1'b0);
        applyStimulus(2'd0, 0, 0, 1'b0);

        // Abort a burst after two beats have been accepted.
        @(negedge clk);
        start = 1'b1;
        start_addr = 2'd0;
        len = 3'd4;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkResetValues("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("midrst_nodone", done, 0);
        applyStimulus(2'd2, 2, 0, 1'b0);

        applyStimulus(2'd0, 4, 0, 1'b1);

        mem[0] = 8'h01;
        mem[1] = 8'h11;
        applyStimulus(2'd0, 2, 0, 1'b0);

        for (int n = 0; n < 25; n++) begin
            for (int a = 0; a < 4; a++) mem[a] = 8'($urandom_range(0, 255));
            sa = 2'($urandom_range(0, 3));
            l  = $urandom_range(0, 4);
            applyStimulus(sa, l, 1, (l >= 3) && ($urandom_range(0, 1) == 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_burst_reader.md
# regfile_burst_reader

Read-side sequencer for the data register file. On a start request it walks a contiguous, wrap-around range of register-file addresses, drives the file's combinational read port (`raddr` → `rdata`), and emits each word as one beat on a valid/ready stream, with last-beat marking and a done pulse. It sits between the register file and any downstream consumer: a transmitter, a debug dump, or a DMA-style mover.

## Interface
- `Dwidth`, 8, bits per word; must match the register file.
- `Awidth`, 2, address bits; the file holds 2**Awidth words.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  burst request; sampled only in IDLE.
- `start_addr`  in  Awidth  first address of the burst.
- `len`  in  Awidth+1  beats in the burst, 0..2**Awidth.
- `raddr`  out  Awidth  register-file read address.
- `rdata`  in  Dwidth  register-file read data; combinational from `raddr`.
- `out_data`  out  Dwidth  stream data.
- `out_valid`  out  1  stream beat valid.
- `out_ready`  in  1  consumer accepts the beat.
- `out_last`  out  1  final beat of the burst; qualified by `out_valid`.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  single-cycle pulse at burst completion.

## Operation
- States:
  - IDLE: waits for a start request.
  - RUN: fetches words.
  - DRAIN: last word fetched, waiting for it to be accepted.
- IDLE, `start`=1, `len`≠0: `raddr`←`start_addr`; remaining←`len`; go to RUN.
- IDLE, `start`=1, `len`=0: `done` pulses next cycle; stay IDLE; no beats.
- `start` is ignored outside IDLE.
- RUN, load condition = `!out_valid || out_ready`. On load:
  - `out_data`←`rdata`; `out_valid`←1; `out_last`←(remaining==1).
  - `raddr`←`raddr`+1, wrapping modulo 2**Awidth.
  - remaining decrements.
  - If remaining was 1, go to DRAIN.
- RUN without load: all registers hold.
- DRAIN, `out_valid && out_ready`: `out_valid`←0, `out_last`←0, `done`←1 for one cycle; go to IDLE.
- Output register is a one-entry skid-free buffer.
- While `out_valid && !out_ready`, `out_data`, `out_last` and `raddr` are stable.
- A beat transfers on any edge where `out_valid && out_ready`.
- `len` = 2**Awidth reads every word once, wrapping from start_addr through start_addr-1.
- Register-file writes to addresses not yet fetched are visible in the stream. Words already fetched are not updated.

## Timing
- Reset values: state IDLE, `raddr`=0, `out_data`=0, `out_valid`=0, `out_last`=0, `busy`=0, `done`=0, remaining=0.
- Reset asserted mid-burst: all outputs return to reset values immediately. The burst is abandoned and `done` does not pulse.
- `start` sampled at edge N → `busy`=1 after N. First beat is valid after edge N+1.
- With `out_ready` held high: one beat per cycle, burst of L beats occupies edges N+1..N+L.
  - `done` is high for the cycle after edge N+L+1.
  - `busy` falls at the same edge.
- Next `start` is accepted the cycle `done` is high (state already IDLE).
- `busy` is registered state decode, with no combinational path from inputs.
- `raddr` is registered. `rdata` is only sampled, so there is no combinational path from `rdata` to outputs.

## Configuration
- `REGFILE_READER_PARITY_EN` defined:
  - adds output `out_parity` (1 bit) = XOR of all `out_data` bits (even parity);
  - registered together with `out_data`, reset value 0, held under backpressure.
- `REGFILE_READER_PARITY_EN` undefined: the port and its logic do not exist.
- All other behaviour is identical.

## Test plan
- Preload file 0x11,0x22,0x33,0x44; `start_addr`=0, `len`=4, `out_ready`=1 → 0x11,0x22,0x33,0x44 on consecutive cycles, `out_last` on 0x44, `done` one cycle after the last beat.
- Wrap: `start_addr`=3, `len`=3 → 0x44,0x11,0x22; `out_last` on 0x22.
- Backpressure: `len`=4, `out_ready` low for 3 cycles after the first valid → `out_data` holds 0x11 throughout; then 0x22..0x44 follow with no loss or duplication.
- `len`=0 → `done` pulses one cycle, `out_valid` never asserts, `busy` stays 0.
- `rst_n` pulsed low after 2 beats → `out_valid`/`busy`/`raddr` go to 0 immediately, no `done`; a fresh `start_addr`=2, `len`=2 then returns 0x33,0x44.
- `start` asserted with `start_addr`=1 during a burst → ignored; the stream is unchanged. With parity enabled, check `out_parity`=1 for 0x01 and 0 for 0x11.
